// File: rtl/com_pkg.sv
// Shared types and helpers for the processor-to-interpreter output link.
// The optional parity output is enabled by defining COM_PARITY_EN.
package com_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } com_state_t;

  // Widest chunk the parity helper accepts; narrower chunks are zero-extended.
  localparam int PAR_MAX_W = 64;

  // Even parity: 1 when the chunk holds an odd number of ones.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

  // Elaboration-time configuration checks.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit divides(input int w, input int c);
    return (c > 0) && ((w % c) == 0);
  endfunction

endpackage

// File: rtl/com_fifo.sv
// Word FIFO for captured memory reads: registered count, naturally wrapping
// pointers, flush clears the control state.
module com_fifo
  import com_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("com_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // Storage write; data is not reset, only the pointers give it meaning.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; flush outranks push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/com_stream_tx.sv
// Processor-to-interpreter output link: captures flagged memory reads into a
// FIFO and serializes each word LSB chunk first over valid/ready.
// Define COM_PARITY_EN to add the out_parity output.
module com_stream_tx
  import com_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              com,
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] read_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              fifo_full,
  output logic              overflow,
  output logic              busy
`ifdef COM_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  localparam int NCH   = DATA_W / OUT_W;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);

  if (!divides(DATA_W, OUT_W)) begin : g_bad_width
    $error("com_stream_tx: DATA_W must be a multiple of OUT_W");
  end

  com_state_t        state_p0;
  com_state_t        state_nx;
  logic [IDX_W-1:0]  idx_p0;
  logic [DATA_W-1:0] shreg_p0;
  logic              vld_p0;
  logic              at_last;
  logic              accept;
  logic              capture;
  logic              pop;
  logic              load;
  logic              shift;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full_i;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign capture = com && mem_to_reg;
  assign vld_p0  = (state_p0 == SHIFT);
  assign at_last = (idx_p0 == IDX_LAST);
  assign accept  = vld_p0 && out_ready;

  // Push decision uses the registered full flag, so a same-cycle pop never
  // makes room for the capture.
  com_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (capture),
    .pop   (pop),
    .wdata (read_data),
    .rdata (fifo_rdata),
    .full  (fifo_full_i),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Serializer next-state: load from the FIFO when idle or after the last
  // chunk is accepted (no bubble), otherwise shift one chunk per accept.
  always_comb begin
    state_nx = state_p0;
    pop      = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    case (state_p0)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          if (!at_last) begin
            shift = 1'b1;
          end else if (!fifo_empty) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Serializer control state; flush returns it to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p0 <= IDLE;
      idx_p0   <= '0;
    end else if (flush) begin
      state_p0 <= IDLE;
      idx_p0   <= '0;
    end else begin
      state_p0 <= state_nx;
      if (load)       idx_p0 <= '0;
      else if (shift) idx_p0 <= idx_p0 + IDX_W'(1);
    end
  end

  // Shift register datapath; contents only matter while in SHIFT.
  always_ff @(posedge clk) begin
    if (load)       shreg_p0 <= fifo_rdata;
    else if (shift) shreg_p0 <= shreg_p0 >> OUT_W;
  end

  // Sticky drop indicator, cleared only by reset or flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       overflow <= 1'b0;
    else if (flush)                   overflow <= 1'b0;
    else if (capture && fifo_full_i)  overflow <= 1'b1;
  end

  assign out_valid = vld_p0;
  assign out_data  = vld_p0 ? shreg_p0[OUT_W-1:0] : '0;
  assign out_last  = vld_p0 && at_last;
  assign fifo_full = fifo_full_i;
  assign busy      = (fifo_count != '0) || vld_p0;

`ifdef COM_PARITY_EN
  if (OUT_W > PAR_MAX_W) begin : g_bad_par
    $error("com_stream_tx: OUT_W too wide for the parity helper");
  end
  assign out_parity = vld_p0 && even_parity(PAR_MAX_W'(out_data));
`endif

endmodule

// File: tb/tb_com_stream_tx.sv
// Self-checking bench for com_stream_tx: vector table, hand sequences for
// stall/overflow/reset/flush, a single-chunk instance, and a randomized run
// against a chunk-queue reference model.
module tb_com_stream_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        com = 1'b0;
  logic        com_w = 1'b0;
  logic        mem_to_reg = 1'b0;
  logic [31:0] read_data = '0;
  logic        out_ready = 1'b0;

  logic        out_valid, out_last, fifo_full, overflow, busy;
  logic [7:0]  out_data;
  logic        w_valid, w_last, w_full, w_ovf, w_busy;
  logic [31:0] w_data;
`ifdef COM_PARITY_EN
  logic        out_parity, w_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  com_stream_tx #(.DATA_W(32), .OUT_W(8), .DEPTH(8)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .com        (com),
    .mem_to_reg (mem_to_reg),
    .read_data  (read_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .busy       (busy)
`ifdef COM_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  com_stream_tx #(.DATA_W(32), .OUT_W(32), .DEPTH(2)) u_wide (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .com        (com_w),
    .mem_to_reg (mem_to_reg),
    .read_data  (read_data),
    .out_ready  (out_ready),
    .out_valid  (w_valid),
    .out_data   (w_data),
    .out_last   (w_last),
    .fifo_full  (w_full),
    .overflow   (w_ovf),
    .busy       (w_busy)
`ifdef COM_PARITY_EN
    ,
    .out_parity (w_parity)
`endif
  );

  // Reference model: expected chunk stream as a queue, words in flight count.
  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } chunk_t;

  chunk_t exp_q[$];
  bit     sb_on = 1'b0;
  int     outstanding = 0;

  typedef struct {
    logic        c;
    logic        m;
    logic [31:0] din;
    logic        rdy;
    logic        e_vld;
    logic [7:0]  e_data;
    logic        e_last;
    logic        e_full;
    logic        e_busy;
  } vec_t;

  localparam int NV = 18;
  vec_t tv[NV];

  function automatic vec_t mk(logic c, logic m, logic [31:0] din, logic rdy,
                              logic v, logic [7:0] d, logic l, logic f, logic b);
    vec_t r;
    r.c = c; r.m = m; r.din = din; r.rdy = rdy;
    r.e_vld = v; r.e_data = d; r.e_last = l; r.e_full = f; r.e_busy = b;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      chunk_t c;
      c.d = w[8*i +: 8];
      c.l = (i == 3);
      exp_q.push_back(c);
    end
    outstanding++;
  endtask

  // One clock: score the handshake and captures seen before the edge, then
  // check that a stalled chunk stays put.
  task automatic tick();
    logic       stalled;
    logic [7:0] hd;
    logic       hl;
    chunk_t     c;
    stalled = sb_on && out_valid && !out_ready;
    hd = out_data;
    hl = out_last;
    if (sb_on && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_extra_chunk: got 0x%0h, expected no chunk", out_data);
      end else begin
        c = exp_q.pop_front();
        check("sb_data", 32'(out_data), 32'(c.d));
        check("sb_last", 32'(out_last), 32'(c.l));
        if (c.l) outstanding--;
      end
    end
    if (sb_on && com && mem_to_reg) push_exp(read_data);
    @(posedge clk);
    #1;
    if (stalled) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(hd));
      check("hold_last", 32'(out_last), 32'(hl));
    end
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    com = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      tick();
      n++;
    end
    check({name, "_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic capture_word(input logic [31:0] w);
    com = 1'b1;
    mem_to_reg = 1'b1;
    read_data = w;
    tick();
    com = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;

    tv[0]  = mk(1, 1, 32'hA1B2C3D4, 1, 0, 8'h00, 0, 0, 1);
    tv[1]  = mk(0, 0, 32'h0,        1, 1, 8'hD4, 0, 0, 1);
    tv[2]  = mk(0, 0, 32'h0,        1, 1, 8'hC3, 0, 0, 1);
    tv[3]  = mk(0, 0, 32'h0,        1, 1, 8'hB2, 0, 0, 1);
    tv[4]  = mk(0, 0, 32'h0,        1, 1, 8'hA1, 1, 0, 1);
    tv[5]  = mk(0, 0, 32'h0,        1, 0, 8'h00, 0, 0, 0);
    tv[6]  = mk(1, 0, 32'hFFFFFFFF, 1, 0, 8'h00, 0, 0, 0);
    tv[7]  = mk(0, 1, 32'hFFFFFFFF, 1, 0, 8'h00, 0, 0, 0);
    tv[8]  = mk(1, 1, 32'h11223344, 1, 0, 8'h00, 0, 0, 1);
    tv[9]  = mk(1, 1, 32'h55667788, 1, 1, 8'h44, 0, 0, 1);
    tv[10] = mk(0, 0, 32'h0,        1, 1, 8'h33, 0, 0, 1);
    tv[11] = mk(0, 0, 32'h0,        1, 1, 8'h22, 0, 0, 1);
    tv[12] = mk(0, 0, 32'h0,        1, 1, 8'h11, 1, 0, 1);
    tv[13] = mk(0, 0, 32'h0,        1, 1, 8'h88, 0, 0, 1);
    tv[14] = mk(0, 0, 32'h0,        1, 1, 8'h77, 0, 0, 1);
    tv[15] = mk(0, 0, 32'h0,        1, 1, 8'h66, 0, 0, 1);
    tv[16] = mk(0, 0, 32'h0,        1, 1, 8'h55, 1, 0, 1);
    tv[17] = mk(0, 0, 32'h0,        1, 0, 8'h00, 0, 0, 0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single word, then back-to-back words, from the vector table.
    for (int i = 0; i < NV; i++) begin
      com = tv[i].c;
      mem_to_reg = tv[i].m;
      read_data = tv[i].din;
      out_ready = tv[i].rdy;
      tick();
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tv[i].e_vld));
      check($sformatf("v%0d_data", i), 32'(out_data), 32'(tv[i].e_data));
      check($sformatf("v%0d_last", i), 32'(out_last), 32'(tv[i].e_last));
      check($sformatf("v%0d_full", i), 32'(fifo_full), 32'(tv[i].e_full));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].e_busy));
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'd0);
    end
    com = 1'b0;
    mem_to_reg = 1'b0;

    // Back-pressure mid-word holds the current chunk.
    out_ready = 1'b0;
    capture_word(32'hDEADBEEF);
    tick();
    check("stall_first", 32'(out_data), 32'hEF);
    out_ready = 1'b1;
    tick();
    check("stall_second", 32'(out_data), 32'hBE);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("stall%0d_data", i), 32'(out_data), 32'hBE);
      check($sformatf("stall%0d_last", i), 32'(out_last), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("resume_data", 32'(out_data), 32'hAD);
    tick();
    check("resume_last_data", 32'(out_data), 32'hDE);
    check("resume_last", 32'(out_last), 32'd1);
    tick();
    check("resume_idle", 32'(out_valid), 32'd0);

    // Fill to overflow with the sink stalled; the first word sits in the
    // serializer, so the FIFO fills on the 9th capture and the 10th drops.
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      w = 32'h01010101 * (k + 1);
      capture_word(w);
      check($sformatf("fill%0d_full", k), 32'(fifo_full), 32'(k >= 8));
      check($sformatf("fill%0d_ovf", k), 32'(overflow), 32'(k >= 9));
    end
    for (int k = 0; k < 9; k++) push_exp(32'h01010101 * (k + 1));
    sb_on = 1'b1;
    drain("fill_drain", 100);
    sb_on = 1'b0;
    check("fill_ovf_sticky", 32'(overflow), 32'd1);
    check("fill_full_after", 32'(fifo_full), 32'd0);

    // Asynchronous reset in the middle of a word.
    out_ready = 1'b0;
    capture_word(32'h12345678);
    tick();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb_on = 1'b1;
    out_ready = 1'b1;
    capture_word(32'hCAFE0001);
    drain("post_rst", 50);
    sb_on = 1'b0;

    // Flush clears everything and beats a same-cycle capture.
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) capture_word(32'h10000000 + k);
    check("pre_flush_ovf", 32'(overflow), 32'd1);
    flush = 1'b1;
    capture_word(32'hBAD0BAD0);
    flush = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_ovf", 32'(overflow), 32'd0);
    check("flush_full", 32'(fifo_full), 32'd0);
    tick();
    check("flush_drop_busy", 32'(busy), 32'd0);
    sb_on = 1'b1;
    out_ready = 1'b1;
    capture_word(32'h0F1E2D3C);
    drain("post_flush", 50);
    sb_on = 1'b0;

    // Single-chunk build: one chunk per word, always last.
    out_ready = 1'b1;
    com_w = 1'b1;
    mem_to_reg = 1'b1;
    read_data = 32'hCAFEF00D;
    tick();
    com_w = 1'b0;
    check("wide_cap_valid", 32'(w_valid), 32'd0);
    check("wide_cap_busy", 32'(w_busy), 32'd1);
    tick();
    check("wide_valid", 32'(w_valid), 32'd1);
    check("wide_data", w_data, 32'hCAFEF00D);
    check("wide_last", 32'(w_last), 32'd1);
`ifdef COM_PARITY_EN
    check("wide_parity", 32'(w_parity), 32'(^32'hCAFEF00D));
`endif
    tick();
    check("wide_idle", 32'(w_valid), 32'd0);
    check("wide_busy", 32'(w_busy), 32'd0);

`ifdef COM_PARITY_EN
    // Parity of chunks 0x07, 0x03 and zero chunks; 0 in IDLE.
    check("par_idle", 32'(out_parity), 32'd0);
    capture_word(32'h00000307);
    tick();
    check("par_c0_data", 32'(out_data), 32'h07);
    check("par_c0", 32'(out_parity), 32'd1);
    tick();
    check("par_c1", 32'(out_parity), 32'd0);
    tick();
    check("par_c2", 32'(out_parity), 32'd0);
    tick();
    tick();
    check("par_end_idle", 32'(out_parity), 32'd0);
`endif

    // Randomized traffic against the chunk-queue model; captures are held
    // back once DEPTH words are in flight so nothing is dropped.
    sb_on = 1'b1;
    outstanding = 0;
    exp_q.delete();
    for (int n = 0; n < 800; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      com = ($urandom_range(0, 2) == 0);
      mem_to_reg = ($urandom_range(0, 3) != 0);
      read_data = $urandom;
      if (outstanding >= 8) com = 1'b0;
      tick();
    end
    drain("rand_drain", 400);
    sb_on = 1'b0;
    check("rand_ovf", 32'(overflow), 32'd0);
    check("rand_valid_end", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
